// File: rtl/ram_loader_pkg.sv
// Shared types and default sizing for the program RAM loader.
package ram_loader_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 4;
  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned LOAD_LEN       = 2 ** DEF_ADDR_WIDTH;

  typedef enum logic [2:0] {
    StIdle,
    StWaitByte,
    StWrite,
    StReadReq,
    StReadChk,
    StDone
  } state_e;

endpackage

// File: rtl/ram_loader.sv
// Program RAM loader: writes a byte stream to addresses 0..2**ADDR_WIDTH-1 in order,
// optionally reading each word back to check it, while holding the CPU halted.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned VERIFY     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  cpu_halt,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] error_addr
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] AddrOne  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] byte_q, byte_d;
  logic                  error_q, error_d;
  logic [ADDR_WIDTH-1:0] error_addr_q, error_addr_d;

  // State, address counter, byte register and sticky error capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      byte_q       <= '0;
      error_q      <= 1'b0;
      error_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      byte_q       <= byte_d;
      error_q      <= error_d;
      error_addr_q <= error_addr_d;
    end
  end

  // Next-state logic; the last word always ends the load, so addr never wraps.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    byte_d       = byte_q;
    error_d      = error_q;
    error_addr_d = error_addr_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          addr_d       = '0;
          error_d      = 1'b0;
          error_addr_d = '0;
          state_d      = StWaitByte;
        end
      end
      StWaitByte: begin
        if (in_valid) begin
          byte_d  = in_data;
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (VERIFY != 0) begin
          state_d = StReadReq;
        end else if (addr_q == LastAddr) begin
          state_d = StDone;
        end else begin
          addr_d  = addr_q + AddrOne;
          state_d = StWaitByte;
        end
      end
      StReadReq: begin
        state_d = StReadChk;
      end
      StReadChk: begin
        if (ram_rdata != byte_q) begin
          // Abort on first mismatch; later addresses stay untouched.
          error_d      = 1'b1;
          error_addr_d = addr_q;
          state_d      = StDone;
        end else if (addr_q == LastAddr) begin
          state_d = StDone;
        end else begin
          addr_d  = addr_q + AddrOne;
          state_d = StWaitByte;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode only registered state, so reset clears them in the following cycle.
  always_comb begin
    busy        = (state_q != StIdle) && (state_q != StDone);
    cpu_halt    = busy;
    in_ready    = (state_q == StWaitByte);
    ram_we      = (state_q == StWrite);
    ram_oe      = (state_q == StReadReq) || (state_q == StReadChk);
    ram_address = busy ? addr_q : '0;
    ram_wdata   = ram_we ? byte_q : '0;
    done        = (state_q == StDone);
    error       = error_q;
    error_addr  = error_addr_q;
  end

endmodule

// File: doc/ram_loader.md
# ram_loader

Sequential program loader that fills the 16 x 8 program RAM from a byte stream, such as a UART receiver, before the CPU runs. It acts as the bus initiator for the RAM's write-enable / output-enable port. It writes bytes to addresses 0..15 in order and, optionally, reads each one back to check it. It holds the CPU halted while it owns the RAM bus; the top level muxes its RAM signals against the CPU's.

## Interface
Parameters:
- ADDR_WIDTH, 4: RAM address width; load length is 2**ADDR_WIDTH bytes.
- DATA_WIDTH, 8: RAM word and stream byte width.
- VERIFY, 1: 1 = read back and compare every word after writing it; 0 = write only.

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE.
- in_valid  in  1  stream byte valid.
- in_data  in  DATA_WIDTH  stream byte.
- in_ready  out  1  loader accepts a byte; the transfer occurs when in_valid && in_ready.
- ram_we  out  1  RAM write enable (RI).
- ram_oe  out  1  RAM output enable (RO).
- ram_address  out  ADDR_WIDTH  RAM address.
- ram_wdata  out  DATA_WIDTH  data to the RAM data input.
- ram_rdata  in  DATA_WIDTH  RAM data output (tri-state bus, valid only while ram_oe).
- cpu_halt  out  1  high while a load is in progress.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  load finished, whether it passed or failed; held until the next start or reset.
- error  out  1  sticky verify mismatch for the current load.
- error_addr  out  ADDR_WIDTH  address of the first mismatch.

## Operation
- FSM states: IDLE, WAIT_BYTE, WRITE, READ_REQ, READ_CHK, DONE.
- IDLE:
  - start clears addr, error and error_addr, then goes to WAIT_BYTE.
- WAIT_BYTE:
  - in_ready=1.
  - On a handshake, latch in_data into a byte register and go to WRITE.
- WRITE:
  - ram_we=1, ram_address=addr, ram_wdata=byte register, for exactly one cycle.
  - Then go to READ_REQ if VERIFY=1.
  - Otherwise: if addr is the last address go to DONE, else addr+1 and go to WAIT_BYTE.
- READ_REQ:
  - ram_oe=1, ram_address=addr. The RAM registers its read on this edge.
- READ_CHK:
  - ram_oe=1, ram_address=addr. Compare ram_rdata with the byte register in this cycle.
  - Mismatch: set error, set error_addr=addr, go to DONE. The load aborts and the remaining addresses are left untouched.
  - Match: same end-of-word rule as WRITE with VERIFY=0.
- DONE:
  - done=1.
  - start goes to WAIT_BYTE with addr, error and error_addr cleared.
- start is ignored while busy.
- Address wrap: addr never increments past 2**ADDR_WIDTH-1. The last word always ends the load.
- ram_we and ram_oe are never high in the same cycle.
- ram_wdata is 0 outside WRITE. ram_address holds addr in WAIT_BYTE, WRITE, READ_REQ and READ_CHK, and is 0 otherwise.
- cpu_halt = busy.
- Stream bytes offered outside WAIT_BYTE are not accepted (in_ready=0). The producer must hold in_valid and in_data until the handshake.

## Timing
- Reset values:
  - state=IDLE, addr=0, byte register=0.
  - All outputs 0: in_ready, ram_we, ram_oe, ram_address, ram_wdata, cpu_halt, busy, done, error, error_addr.
- Reset has priority over every other input. A reset mid-load returns to IDLE in the next cycle and drops ram_we and ram_oe at once. A partial write is never extended.
- Per-word cost from handshake to the next in_ready:
  - VERIFY=1: 4 cycles (WRITE, READ_REQ, READ_CHK, WAIT_BYTE).
  - VERIFY=0: 2 cycles.
- Minimum full load, with bytes always valid: 1 + 16×4 = 65 cycles from start to done with VERIFY=1; 33 cycles with VERIFY=0.
- done rises in the cycle after the final WRITE (VERIFY=0) or the final READ_CHK (VERIFY=1).
- The RAM read latency of 1 cycle, with output valid only while oe is held, sets the two-cycle ram_oe window. ram_rdata is sampled only in READ_CHK.

## Structure
- Shared package ram_loader_pkg:
  - state enum type.
  - Default widths: ADDR_WIDTH=4, DATA_WIDTH=8.
  - LOAD_LEN = 2**ADDR_WIDTH.
- Implementation is a single module: a registered-output FSM plus an address counter and a byte register. No sub-module is needed.
- The verification bench instantiates the existing 16 x 8 RAM as the load target.

## Test plan
- Happy load, VERIFY=1: start, then stream 0x00..0x0F back-to-back. Required: RAM[i]=i, done high at cycle 65, error=0, cpu_halt low afterwards.
- Stalled stream: in_valid random with about 30% duty, bytes 0xA5 XOR i. Required: each byte written exactly once at the correct address, and in_ready=0 in every cycle outside WAIT_BYTE.
- Verify failure: the bench forces ram_rdata bit 0 inverted at address 5. Required: error=1, error_addr=5, done=1, RAM[6..15] unchanged.
- Reset mid-load: reset asserted while in WRITE at address 3. Required: the next cycle shows IDLE with all outputs 0. A new start then reloads from address 0.
- VERIFY=0 build: 16 bytes streamed. Required: ram_oe never high, done at cycle 33.
- Restart and ignored start: start pulsed during busy has no effect. start in DONE clears error and done and begins a new load at address 0.
